// File: rtl/dsc_pkg.sv
// dsc_pkg: shared types and constants for the stochastic/unary stream decoder.
// Holds the decoder FSM state enum and the legal-STRIDE check used at elaboration.
package dsc_pkg;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_e;

    // Bit k set means STRIDE == k is legal (1, 2 and 4).
    localparam logic [7:0] STRIDE_LEGAL_MASK = 8'b0001_0110;

    function automatic bit stride_legal(input int s);
        return (s >= 0 && s < 8) ? STRIDE_LEGAL_MASK[s[2:0]] : 1'b0;
    endfunction

endpackage

// File: rtl/dsc_popcount.sv
// dsc_popcount: counts the ones in one cycle's slice of the stream.
// Ports: bits_i  - STRIDE stream bits
//        count_o - number of ones, clog2(STRIDE+1) bits
module dsc_popcount #(
    parameter int STRIDE = 1
) (
    input  logic [STRIDE-1:0]             bits_i,
    output logic [$clog2(STRIDE+1)-1:0]   count_o
);

    localparam int CW = $clog2(STRIDE + 1);

    always_comb begin
        count_o = '0;
        for (int k = 0; k < STRIDE; k++) count_o = count_o + CW'(bits_i[k]);
    end

endmodule

// File: rtl/dsc_sn_decoder.sv
// dsc_sn_decoder: decodes a unary/stochastic bit stream over a 2^WIDTH-position window into binary.
// Ports: clk, rst (async, active-low), en (consume sn_in this cycle), clr (sync window restart),
//        sn_in (STRIDE stream bits, bit k = position pos+k), bin_out/out_valid/out_ready (result
//        handshake), win_last (this enabled cycle closes the window).
// Option: DSC_DEC_DROP_ERR_EN adds sticky drop_err, set when an unconsumed result is overwritten.
module dsc_sn_decoder
    import dsc_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STRIDE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [STRIDE-1:0] sn_in,
    output logic [WIDTH-1:0]  bin_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              win_last
`ifdef DSC_DEC_DROP_ERR_EN
    ,
    output logic              drop_err
`endif
);

    localparam int CW = $clog2(STRIDE + 1);
    localparam logic [WIDTH-1:0] LAST_POS = WIDTH'((1 << WIDTH) - STRIDE);

    if (!stride_legal(STRIDE)) begin : g_bad_stride
        $error("dsc_sn_decoder: STRIDE=%0d is illegal (use 1, 2 or 4)", STRIDE);
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic [WIDTH:0]   acc_q, acc_d, acc_sum;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             valid_q, valid_d;
    logic [CW-1:0]    pc;
    logic             close;

    dsc_popcount #(.STRIDE(STRIDE)) u_popcount (
        .bits_i  (sn_in),
        .count_o (pc)
    );

    // acc never exceeds 2^WIDTH here, so WIDTH+1 bits hold the full-window sum.
    assign acc_sum  = acc_q + (WIDTH+1)'(pc);
    assign win_last = en && (pos_q == LAST_POS);
    assign close    = win_last && !clr;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        acc_d   = acc_q;
        bin_d   = bin_q;
        valid_d = valid_q && !out_ready;
        if (clr) begin
            state_d = IDLE;
            pos_d   = '0;
            acc_d   = '0;
        end else if (en) begin
            state_d = ACCUM;
            pos_d   = pos_q + WIDTH'(STRIDE);
            acc_d   = close ? '0 : acc_sum;
        end
        // A closing window always wins the output register, dropping any unconsumed value.
        if (close) begin
            bin_d   = acc_sum[WIDTH] ? '1 : acc_sum[WIDTH-1:0];
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            acc_q   <= '0;
            bin_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            acc_q   <= acc_d;
            bin_q   <= bin_d;
            valid_q <= valid_d;
        end
    end

    assign bin_out   = bin_q;
    assign out_valid = valid_q;

`ifdef DSC_DEC_DROP_ERR_EN
    logic drop_q, drop_d;

    assign drop_d = clr ? 1'b0 : (drop_q || (close && valid_q && !out_ready));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_q <= 1'b0;
        else      drop_q <= drop_d;
    end

    assign drop_err = drop_q;
`endif

endmodule

// File: tb/tb_dsc_sn_decoder.sv
// tb_dsc_sn_decoder: scoreboard bench for dsc_sn_decoder (WIDTH=4, STRIDE=1 and STRIDE=4 instances).
module tb_dsc_sn_decoder;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en1 = 1'b0, clr1 = 1'b0, rdy1 = 1'b1;
    logic [0:0] sn1 = '0;
    logic [3:0] bin1;
    logic       v1, last1;
    logic       en4 = 1'b0, clr4 = 1'b0, rdy4 = 1'b1;
    logic [3:0] sn4 = '0;
    logic [3:0] bin4;
    logic       v4, last4;
`ifdef DSC_DEC_DROP_ERR_EN
    logic       drop1, drop4;
`endif

    dsc_sn_decoder #(.WIDTH(4), .STRIDE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .clr(clr1), .sn_in(sn1),
        .bin_out(bin1), .out_valid(v1), .out_ready(rdy1), .win_last(last1)
`ifdef DSC_DEC_DROP_ERR_EN
        , .drop_err(drop1)
`endif
    );

    dsc_sn_decoder #(.WIDTH(4), .STRIDE(4)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .clr(clr4), .sn_in(sn4),
        .bin_out(bin4), .out_valid(v4), .out_ready(rdy4), .win_last(last4)
`ifdef DSC_DEC_DROP_ERR_EN
        , .drop_err(drop4)
`endif
    );

    always #5 clk = ~clk;

    int errs = 0;
    int chks = 0;
    int q1[$];
    int q4[$];
    int npos1 = 0, nones1 = 0, npos4 = 0, nones4 = 0;
    bit drop_exp = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        chks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: a window is 16 enabled positions; its result is the ones count, capped at 15.
    // A result completing while an older one is still unconsumed and not being taken replaces it.
    task automatic step1(input bit e, input bit b, input bit r, input bit c);
        int v;
        @(posedge clk);
        #1;
        en1 = e; sn1[0] = b; rdy1 = r; clr1 = c;
        if (c) begin
            npos1 = 0; nones1 = 0; drop_exp = 1'b0;
        end else if (e) begin
            nones1 += int'(b);
            npos1++;
            if (npos1 == N) begin
                v = (nones1 > N - 1) ? N - 1 : nones1;
                if (!r && q1.size() > 0) begin
                    void'(q1.pop_back());
                    drop_exp = 1'b1;
                end
                q1.push_back(v);
                npos1 = 0; nones1 = 0;
            end
        end
    endtask

    task automatic step4(input bit e, input logic [3:0] b);
        @(posedge clk);
        #1;
        en4 = e; sn4 = b;
        if (e) begin
            nones4 += $countones(b);
            npos4 += 4;
            if (npos4 == N) begin
                q4.push_back((nones4 > N - 1) ? N - 1 : nones4);
                npos4 = 0; nones4 = 0;
            end
        end
    endtask

    task automatic window1(input int val, input bit r);
        for (int p = 0; p < N; p++) step1(1'b1, p < val, r, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (v1 && rdy1) begin
                if (q1.size() == 0) check("spurious_valid1", int'(v1), 0);
                else check("bin1", int'(bin1), q1.pop_front());
            end
            if (v4 && rdy4) begin
                if (q4.size() == 0) check("spurious_valid4", int'(v4), 0);
                else check("bin4", int'(bin4), q4.pop_front());
            end
        end
    end

    initial begin
        #2;
        check("rst_bin1", int'(bin1), 0);
        check("rst_valid1", int'(v1), 0);
        check("rst_bin4", int'(bin4), 0);
        check("rst_valid4", int'(v4), 0);
        #10 rst = 1'b1;

        // Value-5 comparator stream, en held high: one-cycle latency after the 16th bit.
        repeat (3) step1(1'b0, 1'b0, 1'b1, 1'b0);
        for (int p = 0; p < N; p++) begin
            step1(1'b1, p < 5, 1'b0, 1'b0);
            if (p == N - 2) check("win_last_early", int'(last1), 0);
            if (p == N - 1) begin
                check("win_last", int'(last1), 1);
                check("valid_before_close", int'(v1), 0);
            end
        end
        step1(1'b0, 1'b0, 1'b0, 1'b0);
        check("valid_after_close", int'(v1), 1);
        check("bin_value5", int'(bin1), 5);
        step1(1'b0, 1'b0, 1'b1, 1'b0);

        // Alternating en with a value-9 stream; disabled cycles carry junk that must be ignored.
        for (int i = 0; i < 2 * N; i++) begin
            if (i % 2 == 0) step1(1'b1, (i / 2) < 9, 1'b1, 1'b0);
            else step1(1'b0, 1'($urandom), 1'b1, 1'b0);
        end
        repeat (2) step1(1'b0, 1'b0, 1'b1, 1'b0);

        // Consumer stalled across windows 3 then 7: only 7 survives.
        window1(3, 1'b0);
        window1(7, 1'b0);
        step1(1'b0, 1'b0, 1'b0, 1'b0);
        check("overwrite_valid", int'(v1), 1);
        check("overwrite_bin", int'(bin1), 7);
`ifdef DSC_DEC_DROP_ERR_EN
        check("drop_err_set", int'(drop1), int'(drop_exp));
`endif
        step1(1'b0, 1'b0, 1'b1, 1'b0);

        // Abort at position 8, then a clean value-6 window.
        for (int p = 0; p < 8; p++) step1(1'b1, 1'b1, 1'b1, 1'b0);
        step1(1'b1, 1'b1, 1'b1, 1'b1);
        step1(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef DSC_DEC_DROP_ERR_EN
        check("drop_err_clr", int'(drop1), 0);
`endif
        window1(6, 1'b1);
        repeat (2) step1(1'b0, 1'b0, 1'b1, 1'b0);

        // STRIDE=4: four all-ones nibbles saturate to 15.
        for (int c = 0; c < 4; c++) begin
            step4(1'b1, 4'hF);
            if (c == 3) check("win_last4", int'(last4), 1);
        end
        step4(1'b0, 4'h0);
        check("sat_valid4", int'(v4), 1);
        check("sat_bin4", int'(bin4), 15);
        for (int w = 0; w < 10; w++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 3) == 0) step4(1'b0, 4'($urandom));
                step4(1'b1, 4'($urandom));
            end
        end
        repeat (2) step4(1'b0, 4'h0);

        // Partial window of 10 bits, then asynchronous reset between clock edges.
        window1(5, 1'b1);
        for (int p = 0; p < 10; p++) step1(1'b1, 1'b1, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("async_rst_bin1", int'(bin1), 0);
        check("async_rst_valid1", int'(v1), 0);
        check("async_rst_last1", int'(last1), 0);
        check("async_rst_bin4", int'(bin4), 0);
        q1.delete(); q4.delete();
        npos1 = 0; nones1 = 0; npos4 = 0; nones4 = 0; drop_exp = 1'b0;
        en1 = 1'b0;
        #12 rst = 1'b1;
        window1(2, 1'b1);
        step1(1'b0, 1'b0, 1'b1, 1'b0);
        check("post_rst_bin", int'(bin1), 2);

        // Random windows with en gaps, random ready and occasional restarts.
        for (int i = 0; i < 800; i++) begin
            int v;
            bit c;
            v = $urandom_range(0, 16);
            c = ($urandom_range(0, 59) == 0);
            step1($urandom_range(0, 3) != 0, (npos1 < v) ^ ($urandom_range(0, 7) == 0),
                  1'($urandom), c);
        end

        repeat (4) step1(1'b0, 1'b0, 1'b1, 1'b0);
        check("drain1", q1.size(), 0);
        check("drain4", q4.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule

// File: doc/dsc_sn_decoder.md
DSC_SN_DECODER -- requirements
Module: dsc_sn_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 4; binary resolution; the window is 2^WIDTH bit positions.
REQ-002 SHALL have parameter STRIDE, default 1; stream bits consumed per enabled cycle; legal values 1, 2, 4.
REQ-003 SHALL have port clk, input, 1 bit; the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset, asynchronous, active-low.
REQ-005 SHALL have port en, input, 1 bit; sample sn_in and advance the window this cycle.
REQ-006 SHALL have port clr, input, 1 bit; synchronous window restart.
REQ-007 SHALL have port sn_in, input, STRIDE bits; unary/stochastic stream bits; bit k is window position pos+k.
REQ-008 SHALL have port bin_out, output, WIDTH bits; decoded binary value.
REQ-009 SHALL have port out_valid, output, 1 bit; bin_out holds an unconsumed result.
REQ-010 SHALL have port out_ready, input, 1 bit; consumer accepts the result.
REQ-011 SHALL have port win_last, output, 1 bit; the current enabled cycle closes the window (combinational from state and en).

Function
REQ-012 SHALL implement states IDLE and ACCUM. IDLE->ACCUM on first en=1 (that cycle's bits are counted). ACCUM->IDLE on clr.
REQ-013 SHALL hold a position counter pos of WIDTH bits; per en cycle pos += STRIDE, wrapping mod 2^WIDTH.
REQ-014 SHALL hold an accumulator acc of WIDTH+1 bits; per en cycle acc += popcount(sn_in).
REQ-015 SHALL treat en=0 cycles as having no effect on pos or acc.
REQ-016 SHALL close the window when pos+STRIDE == 2^WIDTH with en=1. That edge: bin_out <= min(acc+popcount(sn_in), 2^WIDTH-1), out_valid <= 1, acc <= 0, pos <= 0. Latency is one cycle after the last bit.
REQ-017 SHALL saturate: a window of all ones yields 2^WIDTH-1, never wrapping to 0.
REQ-018 SHALL follow this handshake: transfer occurs when out_valid && out_ready; out_valid clears the next edge unless a new window closes on that same edge, in which case out_valid stays 1 with the new value.
REQ-019 SHALL handle a window close while out_valid=1 and out_ready=0 by overwriting bin_out with the new result (drop of the older value).
REQ-020 SHALL handle clr=1 as follows: pos <= 0, acc <= 0, state <= IDLE; the bits on that cycle are discarded; bin_out and out_valid are unaffected. clr has priority over en.
REQ-021 SHALL keep the bin_out value stable while out_valid=1, except as given in REQ-019.

Reset
REQ-022 SHALL apply the following when rst=0, asynchronously: state IDLE, pos 0, acc 0, bin_out 0, out_valid 0, drop_err 0.
REQ-023 SHALL discard a partial window on reset mid-window; the first window after release starts at position 0.

Configuration
REQ-024 SHALL support macro DSC_DEC_DROP_ERR_EN. When defined, it adds output port drop_err (1 bit), which is set sticky on any REQ-019 overwrite and cleared only by rst or clr.
REQ-025 SHALL, when DSC_DEC_DROP_ERR_EN is undefined, have no drop_err port and no associated flop; all other behaviour is identical.

Structure
REQ-026 SHALL place the state enum (IDLE, ACCUM) and the legal-STRIDE check constant in shared package dsc_pkg.
REQ-027 SHALL implement popcount of sn_in in sub-module dsc_popcount (parameter STRIDE; output clog2(STRIDE+1) bits).
REQ-028 SHALL flag an illegal STRIDE at elaboration.

Verification (WIDTH=4)
REQ-029 SHALL cover: STRIDE=1, en held high, stream from a value-5 counter comparator (5 ones, then 11 zeros) -> bin_out=5, out_valid=1 one cycle after the 16th bit.
REQ-030 SHALL cover: STRIDE=4, 4 cycles of sn_in=4'b1111 with en=1 -> bin_out=15 (saturated), out_valid after cycle 4.
REQ-031 SHALL cover: en toggled 1/0 alternately with STRIDE=1, value-9 stream -> bin_out=9 after 32 cycles, with zero-en cycles ignored.
REQ-032 SHALL cover: out_ready=0 across two windows (values 3, then 7) -> bin_out=7; drop_err=1 when DSC_DEC_DROP_ERR_EN is defined.
REQ-033 SHALL cover: clr at position 8 of a window, then a full value-6 window -> bin_out=6 with no residue from the aborted window.
REQ-034 SHALL cover: rst asserted at position 10 -> all outputs 0 immediately (asynchronously); the next full value-2 window -> bin_out=2.
